// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the RV32I core: stall/flush for load-use, taken jumps and multi-cycle ops.
// Optional PIPE_CTRL_PERF_EN adds saturating stall-cycle and jump counters with a synchronous clear.
module pipe_ctrl #(
  parameter int FLUSH_DEPTH = 1,
  parameter int MC_TIMEOUT  = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             ex_is_load_i,
  input  logic             ex_reg_wen_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_ren_i,
  input  logic             id_rs2_ren_i,
  input  logic             mc_start_i,
  input  logic             mc_done_i,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             stall_pc_o,
  output logic             stall_if_id_o,
  output logic             stall_id_ex_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             mc_abort_o,
  output logic             busy_o,
`ifdef PIPE_CTRL_PERF_EN
  input  logic             perf_clr_i,
  output logic [CNT_W-1:0] perf_stall_cyc_o,
  output logic [CNT_W-1:0] perf_flush_cnt_o,
`endif
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_FLUSH = 2'd1, S_MC_WAIT = 2'd2} state_t;

  localparam logic [3:0]       FD_RELOAD = 4'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] MC_LAST   = CNT_W'(MC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic        load_use;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        stall_front;
  logic        stall_idex;
  logic        flush_ifid;
  logic        flush_idex;
  logic        abort;

  assign load_use = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i != 5'd0) &
                    ((id_rs1_ren_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                     (id_rs2_ren_i & (id_rs2_addr_i == ex_rd_addr_i)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      fcnt_q  <= 4'd0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    mcnt_d      = mcnt_q;
    jump_en     = 1'b0;
    jump_addr   = 32'd0;
    stall_front = 1'b0;
    stall_idex  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    abort       = 1'b0;
    case (state_q)
      S_RUN: begin
        if (jump_en_i) begin
          jump_en    = 1'b1;
          jump_addr  = jump_addr_i;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = S_FLUSH;
            fcnt_d  = FD_RELOAD;
          end
        end else if (mc_start_i) begin
          state_d = S_MC_WAIT;
          mcnt_d  = '0;
        end else if (load_use) begin
          stall_front = 1'b1;
          flush_idex  = 1'b1;
        end
      end
      S_FLUSH: begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        if (jump_en_i) begin
          jump_en   = 1'b1;
          jump_addr = jump_addr_i;
          fcnt_d    = FD_RELOAD;
        end else if (fcnt_q <= 4'd1) begin
          state_d = S_RUN;
          fcnt_d  = 4'd0;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      S_MC_WAIT: begin
        // Done wins over timeout when both land in the same cycle.
        if (mc_done_i) begin
          state_d = S_RUN;
          mcnt_d  = '0;
        end else if (mcnt_q == MC_LAST) begin
          abort      = 1'b1;
          flush_idex = 1'b1;
          state_d    = S_RUN;
          mcnt_d     = '0;
        end else begin
          stall_front = 1'b1;
          stall_idex  = 1'b1;
          if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_RUN;
        fcnt_d  = 4'd0;
        mcnt_d  = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, even with live inputs.
  assign jump_en_o     = ~rst & jump_en;
  assign jump_addr_o   = rst ? 32'd0 : jump_addr;
  assign stall_pc_o    = ~rst & stall_front;
  assign stall_if_id_o = ~rst & stall_front & ~flush_ifid;
  assign stall_id_ex_o = ~rst & stall_idex & ~flush_idex;
  assign flush_if_id_o = ~rst & flush_ifid;
  assign flush_id_ex_o = ~rst & flush_idex;
  assign mc_abort_o    = ~rst & abort;
  assign busy_o        = ~rst & (state_q != S_RUN);
  assign dbg_state_o   = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_stall_q;
  logic [CNT_W-1:0] perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else if (perf_clr_i) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_pc_o && perf_stall_q != '1) perf_stall_q <= perf_stall_q + CNT_ONE;
      if (jump_en_o && perf_flush_q != '1) perf_flush_q <= perf_flush_q + CNT_ONE;
    end
  end

  assign perf_stall_cyc_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl (FLUSH_DEPTH=3, MC_TIMEOUT=8): directed scenarios then random traffic
// checked cycle by cycle against a remaining-cycles reference model.
module tb_pipe_ctrl;
  localparam int FD    = 3;
  localparam int MCT   = 8;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        ex_is_load_i, ex_reg_wen_i;
  logic [4:0]  ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i;
  logic        id_rs1_ren_i, id_rs2_ren_i;
  logic        mc_start_i, mc_done_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        stall_pc_o, stall_if_id_o, stall_id_ex_o;
  logic        flush_if_id_o, flush_id_ex_o, mc_abort_o, busy_o;
  logic [1:0]  dbg_state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic             perf_clr_i;
  logic [CNT_W-1:0] perf_stall_cyc_o, perf_flush_cnt_o;
  int               m_perf_stall, m_perf_flush;
`endif

  pipe_ctrl #(.FLUSH_DEPTH(FD), .MC_TIMEOUT(MCT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .ex_is_load_i(ex_is_load_i), .ex_reg_wen_i(ex_reg_wen_i), .ex_rd_addr_i(ex_rd_addr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_ren_i(id_rs1_ren_i), .id_rs2_ren_i(id_rs2_ren_i),
    .mc_start_i(mc_start_i), .mc_done_i(mc_done_i),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o), .stall_id_ex_o(stall_id_ex_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .mc_abort_o(mc_abort_o), .busy_o(busy_o),
`ifdef PIPE_CTRL_PERF_EN
    .perf_clr_i(perf_clr_i), .perf_stall_cyc_o(perf_stall_cyc_o), .perf_flush_cnt_o(perf_flush_cnt_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // flush_left: flush cycles still owed after this one; waiting/wait_age: multi-cycle wait progress.
  int flush_left = 0;
  bit waiting    = 1'b0;
  int wait_age   = 0;

  task automatic model_step();
    bit j = 0, sp = 0, sf = 0, sx = 0, fi = 0, fx = 0, ab = 0, bz = 0;
    bit lu;
    lu = ex_is_load_i && ex_reg_wen_i && ex_rd_addr_i != 0 &&
         ((id_rs1_ren_i && id_rs1_addr_i == ex_rd_addr_i) ||
          (id_rs2_ren_i && id_rs2_addr_i == ex_rd_addr_i));
    if (rst) begin
      flush_left = 0;
      waiting    = 0;
      wait_age   = 0;
    end else begin
      bz = waiting || flush_left > 0;
      if (waiting) begin
        if (mc_done_i) waiting = 0;
        else if (wait_age == MCT - 1) begin ab = 1; fx = 1; waiting = 0; end
        else begin sp = 1; sf = 1; sx = 1; wait_age++; end
      end else if (flush_left > 0) begin
        fi = 1; fx = 1;
        if (jump_en_i) begin j = 1; flush_left = FD - 1; end
        else flush_left--;
      end else if (jump_en_i) begin
        j = 1; fi = 1; fx = 1; flush_left = FD - 1;
      end else if (mc_start_i) begin
        waiting = 1; wait_age = 0;
      end else if (lu) begin
        sp = 1; sf = 1; fx = 1;
      end
    end
    // A register told to both hold and flush gets flushed.
    exp_q.push_back({24'd0, j, sp, sf & ~fi, sx & ~fx, fi, fx, ab, bz});
    exp_q.push_back(j ? jump_addr_i : 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    if (rst || perf_clr_i) begin
      m_perf_stall = 0; m_perf_flush = 0;
    end else begin
      if (sp && m_perf_stall < (1 << CNT_W) - 1) m_perf_stall++;
      if (j && m_perf_flush < (1 << CNT_W) - 1) m_perf_flush++;
    end
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    jump_en_i = 0; jump_addr_i = 0;
    ex_is_load_i = 0; ex_reg_wen_i = 0; ex_rd_addr_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rs1_ren_i = 0; id_rs2_ren_i = 0;
    mc_start_i = 0; mc_done_i = 0;
`ifdef PIPE_CTRL_PERF_EN
    perf_clr_i = 0;
`endif
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_is_load_i = 1; ex_reg_wen_i = 1; ex_rd_addr_i = rd;
    id_rs2_ren_i = 1; id_rs2_addr_i = 5'd5;
  endtask

  // Inputs are applied just after posedge; outputs are compared mid-cycle on negedge.
  task automatic cycle_check();
    logic [7:0]  obs_ctrl;
    logic [31:0] exp_ctrl;
    @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
    check_eq("perf_stall", 32'(perf_stall_cyc_o), 32'(m_perf_stall));
    check_eq("perf_flush", 32'(perf_flush_cnt_o), 32'(m_perf_flush));
`endif
    model_step();
    obs_ctrl = {jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
                flush_if_id_o, flush_id_ex_o, mc_abort_o, busy_o};
    exp_ctrl = exp_q.pop_front();
    check_eq("ctrl{jmp,spc,sifid,sidex,fifid,fidex,abort,busy}", 32'(obs_ctrl), exp_ctrl);
    check_eq("jump_addr", jump_addr_o, exp_q.pop_front());
    check_eq("dbg_state_busy", 32'(dbg_state_o != 2'd0), 32'(exp_ctrl[0]));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) cycle_check();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    rst = 1; jump_en_i = 1; jump_addr_i = 32'h0000_0dea; mc_start_i = 1;
`ifdef PIPE_CTRL_PERF_EN
    m_perf_stall = 0; m_perf_flush = 0;
`endif
    #1;
    cycle_check();
    cycle_check();
    rst = 0;
    idle(2);

    // load-use with matching rd, then rd = 0
    set_load_use(5'd5); cycle_check(); idle(1);
    set_load_use(5'd0); cycle_check(); idle(1);

    // single jump, then a second jump inside the flush window
    jump_en_i = 1; jump_addr_i = 32'h0000_0100; cycle_check(); idle(4);
    jump_en_i = 1; jump_addr_i = 32'h0000_0100; cycle_check(); idle(1);
    jump_en_i = 1; jump_addr_i = 32'h0000_0200; cycle_check(); idle(4);

    // multi-cycle op finishing before timeout, with jumps that must be ignored
    mc_start_i = 1; cycle_check(); clear_inputs();
    for (int i = 0; i < 5; i++) begin
      jump_en_i = 1; jump_addr_i = 32'h0000_0300; cycle_check();
    end
    clear_inputs(); mc_done_i = 1; cycle_check(); idle(2);

    // timeout, then done landing exactly on the timeout cycle
    mc_start_i = 1; cycle_check(); idle(MCT + 1);
    mc_start_i = 1; cycle_check(); idle(MCT - 1);
    mc_done_i = 1; cycle_check(); idle(2);

    // jump + mc_start + load-use together
    jump_en_i = 1; jump_addr_i = 32'h0000_0400; mc_start_i = 1; set_load_use(5'd5);
    cycle_check(); idle(4);

    // reset in the middle of a wait and of a flush
    mc_start_i = 1; cycle_check(); idle(2);
    rst = 1; cycle_check(); rst = 0; idle(2);
    jump_en_i = 1; jump_addr_i = 32'h0000_0500; cycle_check(); clear_inputs();
    rst = 1; cycle_check(); rst = 0; idle(2);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      jump_en_i     = ($urandom_range(0, 7) == 0);
      jump_addr_i   = $urandom;
      ex_is_load_i  = $urandom_range(0, 1);
      ex_reg_wen_i  = $urandom_range(0, 1);
      ex_rd_addr_i  = 5'($urandom_range(0, 3));
      id_rs1_addr_i = 5'($urandom_range(0, 3));
      id_rs2_addr_i = 5'($urandom_range(0, 3));
      id_rs1_ren_i  = $urandom_range(0, 1);
      id_rs2_ren_i  = $urandom_range(0, 1);
      mc_start_i    = ($urandom_range(0, 7) == 0);
      mc_done_i     = ($urandom_range(0, 5) == 0);
`ifdef PIPE_CTRL_PERF_EN
      perf_clr_i    = ($urandom_range(0, 63) == 0);
`endif
      cycle_check();
    end
    rst = 0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
